// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl
// Description : Memory port controller placed after a multi-cycle control
//               unit. Converts per-stage memory commands into a handshaked
//               read or write on a single shared memory bus, holds the
//               fetched instruction (ir) and loaded data (mdr), and stalls
//               the control unit until the access has finished.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,

    // Command interface from the control unit
    input  logic                 i_mem_read,
    input  logic                 d_mem_read,
    input  logic                 d_mem_write,
    input  logic                 i_or_d,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic [WORD_SIZE-1:0] store_data,

    // Memory bus responses
    input  logic                 input_ready,
    input  logic                 ack_output,
    input  logic [WORD_SIZE-1:0] data_in,

    // Memory bus requests
    output logic                 read_m,
    output logic                 write_m,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_oe,

    // Captured data and status back to the datapath / control unit
    output logic [WORD_SIZE-1:0] ir,
    output logic [WORD_SIZE-1:0] mdr,
    output logic                 stall,
    output logic                 mem_error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter value seen during the last allowed wait cycle: the access is
    // abandoned at the edge that closes wait cycle number TIMEOUT.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_is_fetch;   // read destination: 1 -> ir, 0 -> mdr
    logic [CNT_W-1:0]       r_cnt;        // wait cycles elapsed in current access
    logic                   r_read_m;
    logic                   r_write_m;
    logic [WORD_SIZE-1:0]   r_address;
    logic [WORD_SIZE-1:0]   r_data_out;
    logic [WORD_SIZE-1:0]   r_ir;
    logic [WORD_SIZE-1:0]   r_mdr;
    logic                   r_mem_error;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic w_req;
    logic w_conflict;
    logic w_timeout;
    logic w_stall;

    // Any memory command pending from the control unit
    assign w_req      = i_mem_read | d_mem_read | d_mem_write;

    // Two or more commands in one cycle is a control-unit bug worth flagging
    assign w_conflict = (i_mem_read & d_mem_read) |
                        (i_mem_read & d_mem_write) |
                        (d_mem_read & d_mem_write);

    // Last permitted wait cycle reached; a zero TIMEOUT waits forever
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    // Hold the control unit from the request cycle until the access ends;
    // DONE releases it for exactly one cycle so mPC can advance.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            IDLE:    w_stall = w_req;
            RD_WAIT: w_stall = 1'b1;
            WR_WAIT: w_stall = 1'b1;
            DONE:    w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction FSM with registered bus strobes and captured data
    // ------------------------------------------------------------------------
    // Sequences one access per request and owns every registered output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_is_fetch  <= 1'b0;
            r_cnt       <= '0;
            r_read_m    <= 1'b0;
            r_write_m   <= 1'b0;
            r_address   <= '0;
            r_data_out  <= '0;
            r_ir        <= '0;
            r_mdr       <= '0;
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Snapshot the operands so they stay stable while
                        // the control unit is stalled.
                        r_address  <= i_or_d ? alu_out : pc;
                        r_data_out <= store_data;
                        r_cnt      <= '0;
                        if (w_conflict) begin
                            r_mem_error <= 1'b1;
                        end
                        // Priority: write, then load, then fetch
                        if (d_mem_write) begin
                            r_write_m <= 1'b1;
                            r_state   <= WR_WAIT;
                        end else begin
                            r_read_m   <= 1'b1;
                            r_is_fetch <= ~d_mem_read;
                            r_state    <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    // A response on the closing edge wins over the timeout
                    if (input_ready) begin
                        if (r_is_fetch) begin
                            r_ir <= data_in;
                        end else begin
                            r_mdr <= data_in;
                        end
                        r_read_m <= 1'b0;
                        r_state  <= DONE;
                    end else if (w_timeout) begin
                        r_mem_error <= 1'b1;
                        r_read_m    <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                WR_WAIT: begin
                    if (ack_output) begin
                        r_write_m <= 1'b0;
                        r_state   <= DONE;
                    end else if (w_timeout) begin
                        r_mem_error <= 1'b1;
                        r_write_m   <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                DONE: begin
                    // The finished request is still asserted here; ignore it
                    r_state <= IDLE;
                end

                default: begin
                    r_state   <= IDLE;
                    r_read_m  <= 1'b0;
                    r_write_m <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign read_m    = r_read_m;
    assign write_m   = r_write_m;
    assign data_oe   = r_write_m;
    assign address   = r_address;
    assign data_out  = r_data_out;
    assign ir        = r_ir;
    assign mdr       = r_mdr;
    assign stall     = w_stall;
    assign mem_error = r_mem_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_ctrl
// Description : Self-checking bench for mem_port_ctrl. Each access is
//               predicted at transaction level (strobe length, stall length,
//               captured register, sticky error) and compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_ctrl;

    localparam int WS = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_mem_read, d_mem_read, d_mem_write, i_or_d;
    logic [WS-1:0] pc, alu_out, store_data;
    logic          input_ready, ack_output;
    logic [WS-1:0] data_in;
    logic          read_m, write_m, data_oe, stall, mem_error;
    logic [WS-1:0] address, data_out, ir, mdr;

    always #5 clk = ~clk;

    mem_port_ctrl #(
        .WORD_SIZE (WS),
        .TIMEOUT   (TO),
        .CNT_W     (8)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_mem_read  (i_mem_read),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .i_or_d      (i_or_d),
        .pc          (pc),
        .alu_out     (alu_out),
        .store_data  (store_data),
        .input_ready (input_ready),
        .ack_output  (ack_output),
        .data_in     (data_in),
        .read_m      (read_m),
        .write_m     (write_m),
        .address     (address),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .ir          (ir),
        .mdr         (mdr),
        .stall       (stall),
        .mem_error   (mem_error)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Architectural expectations
    logic [WS-1:0] m_ir, m_mdr;
    logic          m_err;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete access. dly = wait cycle in which memory answers
    // (1 = first wait cycle); 0 means memory never answers.
    task automatic run_txn(input logic f, input logic l, input logic s, input logic iod,
                           input logic [WS-1:0] p, input logic [WS-1:0] a,
                           input logic [WS-1:0] sd, input logic [WS-1:0] rd,
                           input int dly);
        logic [WS-1:0] exp_addr;
        logic          is_wr, is_ld, is_fe, tout, done;
        int            exp_wait, wcyc, stall_cnt, strobe_cnt;

        // Transaction-level prediction
        exp_addr = iod ? a : p;
        is_wr    = s;
        is_ld    = !s && l;
        is_fe    = !s && !l && f;
        tout     = (dly == 0) || (dly > TO);
        exp_wait = tout ? TO : dly;
        if (int'(f) + int'(l) + int'(s) > 1) m_err = 1'b1;
        if (tout)       m_err = 1'b1;
        else if (is_ld) m_mdr = rd;
        else if (is_fe) m_ir  = rd;

        @(negedge clk);
        i_mem_read  = f;
        d_mem_read  = l;
        d_mem_write = s;
        i_or_d      = iod;
        pc          = p;
        alu_out     = a;
        store_data  = sd;
        wcyc = 0; stall_cnt = 0; strobe_cnt = 0; done = 1'b0;

        for (int c = 0; c < TO + 10 && !done; c++) begin
            if (c > 0) @(negedge clk);
            data_in     = WS'($urandom);
            input_ready = 1'b0;
            ack_output  = 1'b0;
            if (read_m || write_m) begin
                wcyc++;
                if (wcyc == dly) begin
                    if (is_wr) ack_output = 1'b1;
                    else begin
                        input_ready = 1'b1;
                        data_in     = rd;
                    end
                end else if (is_wr) begin
                    input_ready = 1'($urandom);
                end else begin
                    ack_output  = 1'($urandom);
                end
            end else begin
                // Responses outside a wait state must be ignored
                input_ready = 1'($urandom);
                ack_output  = 1'($urandom);
            end
            #1;
            if (stall) stall_cnt++;
            else       done = 1'b1;
            if (read_m || write_m) begin
                strobe_cnt++;
                chk16("address", address, exp_addr);
                chk1("read_m_kind", read_m, !is_wr);
                chk1("write_m_kind", write_m, is_wr);
                chk1("data_oe", data_oe, is_wr);
                if (is_wr) chk16("data_out", data_out, sd);
            end
        end
        chk1("done_reached", done, 1'b1);
        chki("stall_cycles", stall_cnt, exp_wait + 1);
        chki("strobe_cycles", strobe_cnt, exp_wait);

        // Control unit has advanced: request withdrawn, controller idle
        @(negedge clk);
        i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
        input_ready = 1'b0; ack_output = 1'b0;
        #1;
        chk1("stall_idle", stall, 1'b0);
        chk1("read_m_idle", read_m, 1'b0);
        chk1("write_m_idle", write_m, 1'b0);
        chk16("ir", ir, m_ir);
        chk16("mdr", mdr, m_mdr);
        chk1("mem_error", mem_error, m_err);
    endtask

    task automatic run_random(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, 2));
            run_txn(k == 0, k == 1, k == 2, 1'($urandom),
                    WS'($urandom), WS'($urandom), WS'($urandom), WS'($urandom),
                    int'($urandom_range(1, TO)));
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        i_mem_read  = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; i_or_d = 1'b0;
        pc          = '0;   alu_out    = '0;   store_data  = '0;
        input_ready = 1'b0; ack_output = 1'b0; data_in     = '0;
        m_ir = '0; m_mdr = '0; m_err = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk1("rst_read_m", read_m, 1'b0);
        chk1("rst_write_m", write_m, 1'b0);
        chk16("rst_address", address, 16'h0000);
        chk16("rst_data_out", data_out, 16'h0000);
        chk16("rst_ir", ir, 16'h0000);
        chk16("rst_mdr", mdr, 16'h0000);
        chk1("rst_mem_error", mem_error, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fetch answered in the first wait cycle
        run_txn(1, 0, 0, 0, 16'h0010, 16'h5555, 16'h0000, 16'h6A05, 1);
        // Load with three wait cycles
        run_txn(0, 1, 0, 1, 16'h0011, 16'h0123, 16'h0000, 16'hBEEF, 3);
        // Store acknowledged after two wait cycles
        run_txn(0, 0, 1, 1, 16'h0012, 16'h0040, 16'h1234, 16'h0000, 2);
        // Random single-command accesses, error flag must stay clear
        run_random(12);
        // Response exactly on the last permitted wait cycle
        run_txn(1, 0, 0, 0, 16'h0020, 16'h0000, 16'h0000, 16'hA1B2, TO);

        // Timeout: memory never answers, ir keeps its value
        run_txn(1, 0, 0, 0, 16'h0030, 16'h0000, 16'h0000, 16'hDEAD, 0);
        // Next fetch completes normally, error stays sticky
        run_txn(1, 0, 0, 0, 16'h0031, 16'h0000, 16'h0000, 16'h7777, 1);
        // Conflict: fetch and store together, store wins
        run_txn(1, 0, 1, 1, 16'h0032, 16'h0044, 16'h9876, 16'h0000, 1);

        // Reset during a read wait
        @(negedge clk);
        i_mem_read = 1'b1; i_or_d = 1'b0; pc = 16'h0222;
        @(negedge clk);
        #1;
        chk1("pre_rst_read_m", read_m, 1'b1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("async_rst_read_m", read_m, 1'b0);
        chk16("async_rst_ir", ir, 16'h0000);
        chk16("async_rst_mdr", mdr, 16'h0000);
        chk1("async_rst_err", mem_error, 1'b0);
        i_mem_read = 1'b0;
        m_ir = '0; m_mdr = '0; m_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        input_ready = 1'b1; data_in = 16'hCAFE;
        @(negedge clk);
        input_ready = 1'b0;
        #1;
        chk16("post_rst_ir", ir, 16'h0000);
        chk1("post_rst_read_m", read_m, 1'b0);
        chk1("post_rst_stall", stall, 1'b0);

        // Operation after reset recovery
        run_random(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Sits directly downstream of the multi-cycle control unit.
- Turns its per-stage memory commands (i_mem_read, d_mem_read, d_mem_write, i_or_d) into a handshaked transaction on the single shared memory bus.
- Holds the fetched instruction (IR) and the loaded data (MDR).
- Asserts stall back to the control unit so mPC holds until the access completes.

Parameters:
WORD_SIZE, 16, data/address width (matches `WORD_SIZE)
TIMEOUT, 255, max wait cycles before abort; 0 disables timeout
CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, all state on posedge
reset_n  in  1  asynchronous, active-low reset
i_mem_read  in  1  instruction fetch request (from control unit)
d_mem_read  in  1  data load request
d_mem_write  in  1  data store request
i_or_d  in  1  address select: 0 pc, 1 alu_out
pc  in  WORD_SIZE  program counter
alu_out  in  WORD_SIZE  computed data address
store_data  in  WORD_SIZE  store value (B register)
input_ready  in  1  memory: read data valid on data_in
ack_output  in  1  memory: write accepted
data_in  in  WORD_SIZE  memory read data
read_m  out  1  memory read strobe
write_m  out  1  memory write strobe
address  out  WORD_SIZE  memory address
data_out  out  WORD_SIZE  memory write data
data_oe  out  1  drive data_out onto bus (equals write_m)
ir  out  WORD_SIZE  instruction register
mdr  out  WORD_SIZE  memory data register
stall  out  1  hold control unit (combinational)
mem_error  out  1  sticky: timeout or conflicting request

Behaviour:
- Reset (async, reset_n=0): state IDLE; read_m=0, write_m=0, address=0, data_out=0, ir=0, mdr=0, mem_error=0, wait counter=0. A reset mid-transaction drops the strobes immediately; no capture occurs.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- req = i_mem_read | d_mem_read | d_mem_write.
- IDLE with req, cycle T:
  - latch address (i_or_d ? alu_out : pc), store_data and access kind.
  - go to WR_WAIT if d_mem_write, else RD_WAIT.
  - stall=1 in cycle T.
- Request priority: d_mem_write > d_mem_read > i_mem_read. Two or more asserted in the same cycle sets mem_error; only the highest-priority request is serviced.
- RD_WAIT:
  - read_m=1 (registered), address stable, stall=1.
  - On a posedge with input_ready=1: capture data_in into ir (fetch) or mdr (load), then go to DONE.
- WR_WAIT:
  - write_m=1, data_oe=1, data_out=latched store_data, stall=1.
  - On a posedge with ack_output=1: go to DONE.
- Wait counter:
  - cleared on entry to a wait state; increments each wait cycle.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: set mem_error, go to DONE, leave ir/mdr unchanged.
- DONE: strobes 0, stall=0 for exactly one cycle so the control unit advances; next state is IDLE unconditionally. The still-present old request is never re-issued.
- Minimum latency: memory responds on the first wait cycle → stall high for 2 cycles (T, T+1), low in T+2. Each extra memory wait cycle adds one stall cycle.
- IDLE without req: stall=0, strobes 0, no state change.
- input_ready/ack_output seen in IDLE or DONE are ignored. A response of the wrong kind (ack_output during RD_WAIT) is ignored.
- mem_error clears only on reset.
- ir and mdr hold their values between accesses. Address width equals WORD_SIZE, with no wrap logic (address passes through unchanged).

Test Plan:
- Fetch, pc=0x0010, i_mem_read=1, memory answers 0x6A05 one cycle after read_m rises → address=0x0010, stall high 2 cycles, ir=0x6A05, mdr unchanged, mem_error=0.
- Load, i_or_d=1, alu_out=0x0123, d_mem_read, 3-cycle memory delay → read_m held 3 cycles, stall high 4 cycles, mdr=data_in (0xBEEF), ir unchanged.
- Store, alu_out=0x0040, store_data=0x1234, ack after 2 cycles → write_m=data_oe=1 for 2 cycles, data_out=0x1234, address=0x0040, then DONE, then IDLE; no second write.
- Timeout with TIMEOUT=4, input_ready never asserted → read_m high 4 cycles, mem_error=1, stall drops, ir keeps its old value; next fetch completes normally with mem_error still 1.
- Conflict: i_mem_read and d_mem_write in the same cycle → write serviced, no read_m, mem_error=1.
- Reset mid-RD_WAIT: reset_n low asynchronously → read_m=0 before the next edge, state IDLE, ir=0; a later input_ready pulse is ignored.
